// File: rtl/sqrt_pkg.sv
// Shared types and sizing helpers for the sqrt output drain stage.
package sqrt_pkg;

    localparam int SQRT_DATA_W = 16;
    localparam int SQRT_RES_W  = SQRT_DATA_W / 2;

    typedef struct packed {
        logic [SQRT_RES_W-1:0] res;
        logic [SQRT_RES_W:0]   rem;
        logic                  exact;
    } sqrt_entry_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sqrt_fifo.sv
// Generic synchronous FIFO; a push into a full FIFO is taken only when a pop
// frees the slot in the same cycle, otherwise it is dropped.
module sqrt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
        else if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only observed while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/sqrt_drain.sv
// Output drain after the last sqrt stage: result FIFO, feeder credits and
// optional round-to-nearest of the root (enabled by macro SQRT_ROUND_EN).
module sqrt_drain
    import sqrt_pkg::*;
#(
    parameter int DATA_W     = SQRT_DATA_W,
    parameter int RES_W      = DATA_W / 2,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = cnt_width(FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_i,
    output logic             issue_ok_o,
    input  logic [RES_W-1:0] res_i,
    input  logic [RES_W:0]   rem_i,
    input  logic             vld_i,
    output logic [RES_W-1:0] out_res_o,
    output logic [RES_W:0]   out_rem_o,
    output logic             out_exact_o,
    output logic             out_vld_o,
    input  logic             out_rdy_i,
    output logic             ovf_o
);
    localparam int ENTRY_W = $bits(sqrt_entry_t);

    // The entry struct is sized by the package default, so the width must match.
    if (DATA_W != SQRT_DATA_W || RES_W != SQRT_RES_W || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
        || FIFO_DEPTH < 2) begin : g_bad_cfg
        $error("sqrt_drain: unsupported DATA_W/RES_W/FIFO_DEPTH");
    end

    logic [CNT_W-1:0] inflight_q, inflight_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] occupancy;
    logic [CNT_W:0]   credit_sum;
    logic             fifo_full, fifo_empty, pop, drop;
    logic [RES_W-1:0] root;
    sqrt_entry_t      wr_entry, head;
    logic [ENTRY_W-1:0] head_bits;

`ifdef SQRT_ROUND_EN
    logic [RES_W:0] res_ext, res_inc;
    always_comb begin
        res_ext = {1'b0, res_i};
        res_inc = res_ext + (RES_W+1)'(1);
        root    = res_i;
        if (rem_i > res_ext) root = res_inc[RES_W] ? '1 : res_inc[RES_W-1:0];
    end
`else
    assign root = res_i;
`endif

    always_comb begin
        wr_entry       = '0;
        wr_entry.res   = root;
        wr_entry.rem   = rem_i;
        wr_entry.exact = (rem_i == '0);
    end

    sqrt_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (vld_i),
        .pop_i   (pop),
        .din_i   (wr_entry),
        .dout_o  (head_bits),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (occupancy)
    );

    assign head        = sqrt_entry_t'(head_bits);
    assign out_vld_o   = !fifo_empty;
    assign out_res_o   = fifo_empty ? '0 : head.res;
    assign out_rem_o   = fifo_empty ? '0 : head.rem;
    assign out_exact_o = !fifo_empty && head.exact;
    assign pop         = out_vld_o && out_rdy_i;
    assign drop        = vld_i && fifo_full && !pop;

    // Credit depends only on registered counters, keeping the feeder path short.
    assign credit_sum = {1'b0, occupancy} + {1'b0, inflight_q};
    assign issue_ok_o = credit_sum < (CNT_W+1)'(FIFO_DEPTH);
    assign ovf_o      = ovf_q;

    always_comb begin
        inflight_d = inflight_q;
        unique case ({issue_i, vld_i})
            2'b10:   if (inflight_q != '1) inflight_d = inflight_q + CNT_W'(1);
            2'b01:   if (inflight_q != '0) inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase
        ovf_d = ovf_q || (vld_i && inflight_q == '0) || (issue_i && !issue_ok_o) || drop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_sqrt_drain.sv
// Directed self-checking bench for sqrt_drain; expectations follow SQRT_ROUND_EN.
module tb_sqrt_drain;
    logic       clk = 1'b0;
    logic       rst;
    logic       issue_i, issue_ok_o;
    logic [7:0] res_i;
    logic [8:0] rem_i;
    logic       vld_i;
    logic [7:0] out_res_o;
    logic [8:0] out_rem_o;
    logic       out_exact_o, out_vld_o, out_rdy_i, ovf_o;

    int n_chk  = 0;
    int n_pass = 0;

    sqrt_drain dut (
        .clk         (clk),
        .rst         (rst),
        .issue_i     (issue_i),
        .issue_ok_o  (issue_ok_o),
        .res_i       (res_i),
        .rem_i       (rem_i),
        .vld_i       (vld_i),
        .out_res_o   (out_res_o),
        .out_rem_o   (out_rem_o),
        .out_exact_o (out_exact_o),
        .out_vld_o   (out_vld_o),
        .out_rdy_i   (out_rdy_i),
        .ovf_o       (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue();
        issue_i = 1'b1;
        step();
        issue_i = 1'b0;
    endtask

    task automatic ret(input int r, input int m);
        vld_i = 1'b1;
        res_i = 8'(r);
        rem_i = 9'(m);
        step();
        vld_i = 1'b0;
    endtask

    // res, rem, floor root, rounded root, exact
    int vec [6][5] = '{
        '{ 12,   0,  12,  12, 1},
        '{ 12,  16,  12,  13, 0},
        '{ 12,   6,  12,  12, 0},
        '{200, 200, 200, 200, 0},
        '{200, 201, 200, 201, 0},
        '{255, 510, 255, 255, 0}
    };

    initial begin
        int exp_root;
        rst = 1'b1; issue_i = 1'b0; vld_i = 1'b0; res_i = '0; rem_i = '0; out_rdy_i = 1'b0;
        step();
        step();
        check("rst_vld", out_vld_o, 0);
        check("rst_res", out_res_o, 0);
        check("rst_rem", out_rem_o, 0);
        check("rst_exact", out_exact_o, 0);
        check("rst_ovf", ovf_o, 0);
        check("rst_issue_ok", issue_ok_o, 1);
        rst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
`ifdef SQRT_ROUND_EN
            exp_root = vec[i][3];
`else
            exp_root = vec[i][2];
`endif
            issue();
            check("pre_vld", out_vld_o, 0);
            ret(vec[i][0], vec[i][1]);
            check("vec_vld", out_vld_o, 1);
            check("vec_res", out_res_o, exp_root);
            check("vec_rem", out_rem_o, vec[i][1]);
            check("vec_exact", out_exact_o, vec[i][4]);
            out_rdy_i = 1'b1;
            step();
            out_rdy_i = 1'b0;
            check("vec_popped", out_vld_o, 0);
        end
        check("vec_ovf", ovf_o, 0);

        // Backpressure: fill credits and FIFO with the consumer stalled.
        for (int i = 1; i <= 4; i++) begin
            issue();
            check("bp_issue_ok", issue_ok_o, (i < 4) ? 1 : 0);
        end
        for (int i = 1; i <= 4; i++) ret(i, 0);
        check("bp_full_ok", issue_ok_o, 0);
        check("bp_full_ovf", ovf_o, 0);
        check("bp_head", out_res_o, 1);
        step();
        check("bp_stable", out_res_o, 1);
        issue();
        check("bp_overissue_ovf", ovf_o, 1);

        // Full FIFO: pop and write in the same cycle must not drop the write.
        out_rdy_i = 1'b1;
        ret(5, 0);
        for (int i = 2; i <= 5; i++) begin
            check("drain_vld", out_vld_o, 1);
            check("drain_res", out_res_o, i);
            step();
        end
        out_rdy_i = 1'b0;
        check("drain_empty", out_vld_o, 0);
        check("drain_issue_ok", issue_ok_o, 1);

        // Full FIFO without pop drops the incoming result.
        for (int i = 0; i < 5; i++) issue();
        for (int i = 10; i < 14; i++) ret(i, 0);
        ret(99, 0);
        out_rdy_i = 1'b1;
        for (int i = 10; i < 14; i++) begin
            check("drop_res", out_res_o, i);
            step();
        end
        out_rdy_i = 1'b0;
        check("drop_empty", out_vld_o, 0);

        // Reset mid-stream: 3 buffered, 2 in flight.
        for (int i = 0; i < 5; i++) issue();
        for (int i = 20; i < 23; i++) ret(i, 0);
        check("mid_occ_vld", out_vld_o, 1);
        rst = 1'b1;
        #1;
        check("async_vld", out_vld_o, 0);
        check("async_ovf", ovf_o, 0);
        check("async_issue_ok", issue_ok_o, 1);
        step();
        rst = 1'b0;
        step();
        check("post_rst_ovf", ovf_o, 0);
        ret(7, 0);
        check("stray_ovf", ovf_o, 1);
        check("stray_issue_ok", issue_ok_o, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
